tp84_shared_ram_arbiter: RTL
============================

TP84_SHARED_RAM_ARBITER -- requirements
Module: tp84_shared_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning shared-RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning shared-RAM data width.
REQ-003 SHALL have parameter ACCESS_CYC, default 2, legal 1..15, meaning clocks of ram_cs per access.
REQ-004 SHALL have clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have req_a / req_b  input  1  access request, main CPU / sub CPU.
REQ-007 SHALL have we_a / we_b  input  1  1 = write, 0 = read.
REQ-008 SHALL have addr_a / addr_b  input  ADDR_W  request address.
REQ-009 SHALL have wdata_a / wdata_b  input  DATA_W  write data.
REQ-010 SHALL have ack_a / ack_b  output  1  one-cycle completion pulse.
REQ-011 SHALL have rdata_a / rdata_b  output  DATA_W  read data, held until that port's next read completes.
REQ-012 SHALL have ram_cs, ram_we  output  1  shared-RAM strobes.
REQ-013 SHALL have ram_addr  output  ADDR_W, ram_wdata  output  DATA_W, ram_rdata  input  DATA_W.
REQ-014 SHALL have owner  output  2  00 idle, 01 port A, 10 port B.

Function
REQ-015 SHALL implement states IDLE, GRANT_A, GRANT_B; all outputs registered.
REQ-016 SHALL sample req_x each edge. Requester holds we/addr/wdata stable from req high until ack.
REQ-017 In IDLE with one request: next state is the matching GRANT. ram_cs=1, ram_we=we_x, address/data copied from that port, counter=ACCESS_CYC-1.
REQ-018 With both requests on the same edge: grant the port not granted last (round-robin). last_grant resets to B, so A wins the first tie.
REQ-019 In GRANT: ram_cs and the RAM outputs stay constant for exactly ACCESS_CYC cycles; the counter decrements each edge.
REQ-020 On the edge where counter==0: deassert ram_cs/ram_we, pulse ack_x for one cycle, capture ram_rdata into rdata_x on reads only, update last_grant.
REQ-021 On that same completion edge, a request pending on the other port SHALL be granted directly (no IDLE cycle) with ram_cs high the next cycle. Otherwise the next state is IDLE.
REQ-022 The granted port's own req high in its ack cycle is a new request; it is arbitrated one edge later under REQ-018.
REQ-023 Latency, uncontended: req sampled at edge 0 -> ram_cs high after edges 1..ACCESS_CYC -> ack high after edge ACCESS_CYC+1.
REQ-024 A request dropped before ack SHALL NOT abort a running grant; the access completes and acks.
REQ-025 ack_a and ack_b SHALL never be high in the same cycle; ram_cs is never high outside GRANT states.
REQ-026 owner SHALL equal the current state encoding.

Reset
REQ-027 reset_n low SHALL immediately force: state IDLE, all acks/ram_cs/ram_we 0, ram_addr/ram_wdata/rdata_a/rdata_b 0, owner 00, counter 0, last_grant B.
REQ-028 Reset asserted mid-grant SHALL drop ram_cs asynchronously and never produce ack for the aborted access.
REQ-029 After reset release, the first arbitration SHALL occur on the first rising edge with reset_n high.

Structure
REQ-030 Package tp84_arb_pkg SHALL hold the state enum (IDLE/GRANT_A/GRANT_B), the owner encoding constants and the port enum.
REQ-031 The round-robin pick SHALL be a sub-module tp84_rr_pick2 (inputs req_a, req_b, last_grant; output grant), combinational.
REQ-032 The counter width SHALL be 4 bits, independent of ACCESS_CYC.

Verification
REQ-033 A read only, addr_a=0x123, RAM holds 0x5A there -> ram_cs high 2 cycles, ack_a after edge 3, rdata_a=0x5A.
REQ-034 A and B both request at reset release -> A granted first, B's ram_cs begins the cycle right after A's completion edge, no idle gap.
REQ-035 Both held continuously for 6 accesses -> grants alternate A,B,A,B,A,B, one ack per access.
REQ-036 B write addr 0x7FF data 0xC3, then A read 0x7FF -> rdata_a=0xC3, rdata_b unchanged.
REQ-037 reset_n low in 2nd grant cycle -> ram_cs 0 at once, no ack, all outputs zero.
REQ-038 ACCESS_CYC=1, A only -> ram_cs one cycle, ack_a after edge 2.

Source files
------------

// File: rtl/tp84_arb_pkg.sv
// ---------------------------------------------------------------------------
// tp84_arb_pkg
// Shared definitions for the TP84 shared-RAM arbiter:
//   - owner output encodings (idle / port A / port B)
//   - arbiter state enum, whose values are the owner encodings so the state
//     register can drive the owner output directly
//   - port identifier enum used for round-robin bookkeeping
//   - access counter width (fixed, independent of the access length)
// ---------------------------------------------------------------------------
package tp84_arb_pkg;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = OWNER_IDLE,
        GRANT_A = OWNER_A,
        GRANT_B = OWNER_B
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/tp84_rr_pick2.sv
// ---------------------------------------------------------------------------
// tp84_rr_pick2
// Two-way round-robin picker, purely combinational.
// Ports:
//   req_a, req_b  : requests competing this cycle
//   last_grant    : port served most recently (PORT_A / PORT_B)
//   grant         : chosen port (PORT_A / PORT_B); only meaningful when at
//                   least one request is high
// ---------------------------------------------------------------------------
module tp84_rr_pick2
    import tp84_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        if (req_a && req_b) begin
            // Tie: serve whichever port did not go last.
            grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant = PORT_B;
        end else begin
            grant = PORT_A;
        end
    end

endmodule

// File: rtl/tp84_shared_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tp84_shared_ram_arbiter
// Arbitrates a single-port shared RAM between a main CPU (port A) and a sub
// CPU (port B). Each access holds ram_cs for ACCESS_CYC clocks, then the
// requester receives a one-cycle ack (and read data on reads). Ties are
// resolved round-robin; a request waiting on the other port is granted on
// the completion edge so back-to-back accesses have no idle gap.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   req_x, we_x, addr_x, wdata_x : request side, x = a (main) / b (sub)
//   ack_x, rdata_x               : completion pulse, held read data
//   ram_cs, ram_we, ram_addr,
//   ram_wdata, ram_rdata         : shared-RAM interface
//   owner                        : 00 idle, 01 port A, 10 port B
// All outputs are registered.
// ---------------------------------------------------------------------------
module tp84_shared_ram_arbiter
    import tp84_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACCESS_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYC - 1);

    arb_state_e        state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    port_e             last_grant_q, last_grant_d;
    logic              req_a_q,      req_a_d;
    logic              req_b_q,      req_b_d;
    logic              ack_a_q,      ack_a_d;
    logic              ack_b_q,      ack_b_d;
    logic              ram_cs_q,     ram_cs_d;
    logic              ram_we_q,     ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q,  ram_wdata_d;
    logic [DATA_W-1:0] rdata_a_q,    rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q,    rdata_b_d;

    logic pick;
    logic start_a;
    logic start_b;

    tp84_rr_pick2 u_rr_pick2 (
        .req_a      (req_a_q),
        .req_b      (req_b_q),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        req_a_d      = req_a;
        req_b_d      = req_b;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        ram_cs_d     = ram_cs_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;
        start_a      = 1'b0;
        start_b      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_a_q || req_b_q) begin
                    start_a = (pick == PORT_A);
                    start_b = (pick == PORT_B);
                end
            end
            GRANT_A: begin
                if (cnt_q == '0) begin
                    ack_a_d      = 1'b1;
                    last_grant_d = PORT_A;
                    state_d      = IDLE;
                    ram_cs_d     = 1'b0;
                    ram_we_d     = 1'b0;
                    if (!ram_we_q) begin
                        rdata_a_d = ram_rdata;
                    end
                    // The sample taken now still shows the request being
                    // completed; drop it so only a req seen in the ack cycle
                    // counts as a new request.
                    req_a_d = 1'b0;
                    start_b = req_b_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GRANT_B: begin
                if (cnt_q == '0) begin
                    ack_b_d      = 1'b1;
                    last_grant_d = PORT_B;
                    state_d      = IDLE;
                    ram_cs_d     = 1'b0;
                    ram_we_d     = 1'b0;
                    if (!ram_we_q) begin
                        rdata_b_d = ram_rdata;
                    end
                    req_b_d = 1'b0;
                    start_a = req_a_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new grant (from idle or as a direct hand-over on a completion
        // edge) overrides the strobe deassertion above.
        if (start_a) begin
            state_d     = GRANT_A;
            ram_cs_d    = 1'b1;
            ram_we_d    = we_a;
            ram_addr_d  = addr_a;
            ram_wdata_d = wdata_a;
            cnt_d       = CNT_LOAD;
        end else if (start_b) begin
            state_d     = GRANT_B;
            ram_cs_d    = 1'b1;
            ram_we_d    = we_b;
            ram_addr_d  = addr_b;
            ram_wdata_d = wdata_b;
            cnt_d       = CNT_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_B;
            req_a_q      <= 1'b0;
            req_b_q      <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            req_a_q      <= req_a_d;
            req_b_q      <= req_b_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            ram_cs_q     <= ram_cs_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
        end
    end

    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign owner     = state_q;

endmodule
